// File: rtl/sparse_buffer_drain.sv
// Purpose : tracks completed sparse-buffer entries and drains the oldest ready one
//           (strict in-order or oldest-ready) into a registered output stage.
// Latency : done -> rd_valid_o 1 cycle; read -> out_valid_o 1 cycle; 1 drain/cycle sustained.
// Backpr. : out_allowIn_i low with out_valid_o high stalls reads (rd_valid_o=0,
//           rtn_allowIn_o=0) and holds out_data_o/out_ptr_o stable.
// Ports   : done_* completion events; buf_* sparse buffer occupancy/age;
//           rd_*/rtn_* single-cycle read to the sparse buffer; out_* downstream stage;
//           issue_cnt_o wrapping count of drained entries. SIZE must equal 2**AW.
module sparse_buffer_drain #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int SIZE = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            done_valid_i,
    input  logic [AW-1:0]   done_ptr_i,
    input  logic [SIZE-1:0] buf_valid_i,
    input  logic [AW-1:0]   buf_bottom_ptr_i,
    input  logic            ordered_mode_i,
    input  logic            flush_i,
    output logic            rd_valid_o,
    output logic [AW-1:0]   rd_ptr_o,
    input  logic            rd_allowIn_i,
    input  logic            rtn_valid_i,
    input  logic [DW-1:0]   rtn_data_i,
    output logic            rtn_allowIn_o,
    output logic            out_valid_o,
    input  logic            out_allowIn_i,
    output logic [DW-1:0]   out_data_o,
    output logic [AW-1:0]   out_ptr_o,
    output logic [15:0]     issue_cnt_o
);

    logic [SIZE-1:0] ready_q;
    logic [SIZE-1:0] ready_d;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [AW-1:0]   out_ptr_q;
    logic [15:0]     issue_cnt_q;

    logic [SIZE-1:0] cand;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   sel_ptr;
    logic            sel_found;
    logic            out_free;
    logic            kickoff;

    // Pointer arithmetic wraps naturally in AW bits because SIZE == 2**AW.
    assign oldest = buf_bottom_ptr_i + AW'(1);
    assign cand   = buf_valid_i & ready_q;

    // Age-ordered scan starting at the oldest entry. In ordered mode only the
    // first position of the scan (the oldest entry itself) may be chosen.
    always_comb begin
        logic [AW-1:0] idx;
        sel_found = 1'b0;
        sel_ptr   = '0;
        idx       = '0;
        if (ordered_mode_i) begin
            sel_found = cand[oldest];
            sel_ptr   = oldest;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                idx = oldest + AW'(i);
                if (!sel_found && cand[idx]) begin
                    sel_found = 1'b1;
                    sel_ptr   = idx;
                end
            end
        end
    end

    // The output register can take new data when empty or being handed off.
    assign out_free      = ~out_valid_q | out_allowIn_i;
    assign rtn_allowIn_o = out_free;
    assign rd_valid_o    = out_free & sel_found & ~flush_i;
    assign rd_ptr_o      = rd_valid_o ? sel_ptr : '0;
    assign kickoff       = rd_valid_o & rd_allowIn_i & rtn_valid_i;

    // Set from done events first, then clear on kickoff so that a done and a
    // drain of the same entry in one cycle leaves the entry not ready.
    always_comb begin
        ready_d = ready_q;
        if (flush_i) begin
            ready_d = '0;
        end else begin
            if (done_valid_i && buf_valid_i[done_ptr_i]) begin
                ready_d[done_ptr_i] = 1'b1;
            end
            if (kickoff) begin
                ready_d[rd_ptr_o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ready_q <= '0;
        end else begin
            ready_q <= ready_d;
        end
    end

    // Output stage. kickoff is never asserted during flush, so the flush
    // branch only has to drop the valid bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ptr_q   <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (kickoff) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rtn_data_i;
            out_ptr_q   <= rd_ptr_o;
        end else if (out_allowIn_i) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            issue_cnt_q <= '0;
        end else if (kickoff) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ptr_o   = out_ptr_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_sparse_buffer_drain.sv
// Purpose : self-checking bench for sparse_buffer_drain: directed vector table,
//           hand sequences (backpressure, flush, async reset) and a random run
//           against a queue/array reference model of the drain rules.
module tb_sparse_buffer_drain;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int SIZE = 8;

    logic            clk;
    logic            rstn;
    logic            done_valid;
    logic [AW-1:0]   done_ptr;
    logic [SIZE-1:0] buf_valid;
    logic [AW-1:0]   bottom;
    logic            ordered;
    logic            flush;
    logic            rd_valid;
    logic [AW-1:0]   rd_ptr;
    logic            rd_allow;
    logic            rtn_valid;
    logic [DW-1:0]   rtn_data;
    logic            rtn_allow;
    logic            out_valid;
    logic            out_allow;
    logic [DW-1:0]   out_data;
    logic [AW-1:0]   out_ptr;
    logic [15:0]     issue_cnt;

    sparse_buffer_drain #(.DW(DW), .AW(AW), .SIZE(SIZE)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .done_valid_i     (done_valid),
        .done_ptr_i       (done_ptr),
        .buf_valid_i      (buf_valid),
        .buf_bottom_ptr_i (bottom),
        .ordered_mode_i   (ordered),
        .flush_i          (flush),
        .rd_valid_o       (rd_valid),
        .rd_ptr_o         (rd_ptr),
        .rd_allowIn_i     (rd_allow),
        .rtn_valid_i      (rtn_valid),
        .rtn_data_i       (rtn_data),
        .rtn_allowIn_o    (rtn_allow),
        .out_valid_o      (out_valid),
        .out_allowIn_i    (out_allow),
        .out_data_o       (out_data),
        .out_ptr_o        (out_ptr),
        .issue_cnt_o      (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_ready[SIZE];
    bit          m_ov;
    logic [7:0]  m_od;
    logic [2:0]  m_op;
    logic [15:0] m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < SIZE; i++) m_ready[i] = 0;
        m_ov = 0; m_od = '0; m_op = '0; m_cnt = '0;
    endfunction

    function automatic void model_comb(output bit rv, output int rp, output bit ra);
        int  oldest;
        bit  found;
        bit  free;
        oldest = (int'(bottom) + 1) % SIZE;
        free   = !m_ov || out_allow;
        found  = 0;
        rp     = 0;
        if (ordered) begin
            if (buf_valid[oldest] && m_ready[oldest]) begin
                found = 1; rp = oldest;
            end
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                int p;
                p = (oldest + k) % SIZE;
                if (!found && buf_valid[p] && m_ready[p]) begin
                    found = 1; rp = p;
                end
            end
        end
        ra = free;
        rv = free && found && !flush;
        if (!rv) rp = 0;
    endfunction

    function automatic void model_edge(input bit rv, input int rp);
        bit kick;
        kick = rv && rd_allow && rtn_valid;
        if (flush) begin
            for (int i = 0; i < SIZE; i++) m_ready[i] = 0;
            m_ov = 0;
        end else begin
            if (done_valid && buf_valid[done_ptr]) m_ready[done_ptr] = 1;
            if (kick) begin
                m_ready[rp] = 0;
                m_ov  = 1;
                m_od  = rtn_data;
                m_op  = 3'(rp);
                m_cnt = m_cnt + 16'd1;
            end else if (out_allow) begin
                m_ov = 0;
            end
        end
    endfunction

    // One clock: inputs already driven (posedge+1). Samples combinational
    // outputs at the falling edge, registered outputs 1 time unit after the
    // rising edge. Leaves time at posedge+1.
    task automatic cycle(input bit chk, output logic s_rv, output logic [2:0] s_rp,
                         output logic s_ra);
        bit e_rv, e_ra;
        int e_rp;
        @(negedge clk);
        model_comb(e_rv, e_rp, e_ra);
        s_rv = rd_valid; s_rp = rd_ptr; s_ra = rtn_allow;
        if (chk) begin
            check("m_rd_valid", {31'b0, rd_valid}, {31'b0, e_rv});
            check("m_rd_ptr", {29'b0, rd_ptr}, e_rp);
            check("m_rtn_allowIn", {31'b0, rtn_allow}, {31'b0, e_ra});
        end
        @(posedge clk);
        model_edge(e_rv, e_rp);
        #1;
        if (chk) begin
            check("m_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            check("m_out_ptr", {29'b0, out_ptr}, {29'b0, m_op});
            check("m_out_data", {24'b0, out_data}, {24'b0, m_od});
            check("m_issue_cnt", {16'b0, issue_cnt}, {16'b0, m_cnt});
        end
    endtask

    task automatic set_in(input bit dv, input int dp, input logic [7:0] bv, input int bot,
                          input bit ord, input bit fl, input bit rda, input bit rtv,
                          input logic [7:0] dat, input bit oa);
        done_valid = dv; done_ptr = 3'(dp); buf_valid = bv; bottom = 3'(bot);
        ordered = ord; flush = fl; rd_allow = rda; rtn_valid = rtv;
        rtn_data = dat; out_allow = oa;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit dv; int dp; logic [7:0] bv; int bot; bit ord; bit rda; logic [7:0] dat;
        bit e_rv; int e_rp; bit e_ov; int e_op; logic [7:0] e_od; int e_cnt;
    } vec_t;

    function automatic vec_t mk(bit dv, int dp, logic [7:0] bv, int bot, bit ord, bit rda,
                                logic [7:0] dat, bit e_rv, int e_rp, bit e_ov, int e_op,
                                logic [7:0] e_od, int e_cnt);
        vec_t v;
        v.dv = dv; v.dp = dp; v.bv = bv; v.bot = bot; v.ord = ord; v.rda = rda; v.dat = dat;
        v.e_rv = e_rv; v.e_rp = e_rp; v.e_ov = e_ov; v.e_op = e_op; v.e_od = e_od;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic       s_rv, s_ra;
        logic [2:0] s_rp;

        // oldest-ready drain, bottom 7 -> oldest 0
        vecs.push_back(mk(1, 2, 8'h0F, 7, 0, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 8'h0F, 7, 0, 1, 8'hA2, 1, 2, 1, 2, 8'hA2, 1));
        vecs.push_back(mk(0, 0, 8'h0F, 7, 0, 1, 8'hB0, 1, 0, 1, 0, 8'hB0, 2));
        vecs.push_back(mk(0, 0, 8'h0F, 7, 0, 1, 8'h33, 0, 0, 0, 0, 8'hB0, 2));
        // in-order drain: ptr 2 held until it is the oldest
        vecs.push_back(mk(1, 2, 8'h0F, 7, 1, 1, 8'h44, 0, 0, 0, 0, 8'hB0, 2));
        vecs.push_back(mk(0, 0, 8'h0F, 7, 1, 1, 8'h55, 0, 0, 0, 0, 8'hB0, 2));
        vecs.push_back(mk(1, 0, 8'h0F, 7, 1, 1, 8'hC0, 0, 0, 0, 0, 8'hB0, 2));
        vecs.push_back(mk(0, 0, 8'h0F, 7, 1, 1, 8'hC1, 1, 0, 1, 0, 8'hC1, 3));
        vecs.push_back(mk(1, 1, 8'h0F, 0, 1, 1, 8'hC2, 0, 0, 0, 0, 8'hC1, 3));
        vecs.push_back(mk(0, 0, 8'h0F, 0, 1, 1, 8'hC3, 1, 1, 1, 1, 8'hC3, 4));
        vecs.push_back(mk(0, 0, 8'h0F, 1, 1, 1, 8'hC4, 1, 2, 1, 2, 8'hC4, 5));
        vecs.push_back(mk(0, 0, 8'h0F, 1, 1, 1, 8'h66, 0, 0, 0, 2, 8'hC4, 5));
        // wrap-around: bottom 5 -> oldest 6, then 7, 0, 1
        vecs.push_back(mk(1, 1, 8'hC3, 5, 0, 1, 8'h77, 0, 0, 0, 2, 8'hC4, 5));
        vecs.push_back(mk(1, 6, 8'hC3, 5, 0, 0, 8'h88, 1, 1, 0, 2, 8'hC4, 5));
        vecs.push_back(mk(0, 0, 8'hC3, 5, 0, 1, 8'hD1, 1, 6, 1, 6, 8'hD1, 6));
        vecs.push_back(mk(0, 0, 8'hC3, 5, 0, 1, 8'hD2, 1, 1, 1, 1, 8'hD2, 7));
        vecs.push_back(mk(0, 0, 8'hC3, 5, 0, 1, 8'h99, 0, 0, 0, 1, 8'hD2, 7));
        // done for an invalid entry is ignored, even once it becomes valid
        vecs.push_back(mk(1, 4, 8'hEF, 7, 0, 1, 8'hAA, 0, 0, 0, 1, 8'hD2, 7));
        vecs.push_back(mk(0, 0, 8'hEF, 7, 0, 1, 8'hAB, 0, 0, 0, 1, 8'hD2, 7));
        // done coinciding with kickoff of same ptr: clear wins
        vecs.push_back(mk(1, 3, 8'hFF, 7, 0, 1, 8'hAC, 0, 0, 0, 1, 8'hD2, 7));
        vecs.push_back(mk(1, 3, 8'hFF, 7, 0, 1, 8'hE0, 1, 3, 1, 3, 8'hE0, 8));
        vecs.push_back(mk(0, 0, 8'hFF, 7, 0, 1, 8'hAD, 0, 0, 0, 3, 8'hE0, 8));

        // ---------------- reset ----------------
        rstn = 1'b0;
        set_in(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
        model_reset();
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", {24'b0, out_data}, 0);
        check("rst_out_ptr", {29'b0, out_ptr}, 0);
        check("rst_issue_cnt", {16'b0, issue_cnt}, 0);
        check("rst_rd_valid", {31'b0, rd_valid}, 0);
        check("rst_rtn_allowIn", {31'b0, rtn_allow}, 1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            set_in(v.dv, v.dp, v.bv, v.bot, v.ord, 0, v.rda, 1, v.dat, 1);
            cycle(0, s_rv, s_rp, s_ra);
            check($sformatf("v%0d_rd_valid", i), {31'b0, s_rv}, {31'b0, v.e_rv});
            check($sformatf("v%0d_rd_ptr", i), {29'b0, s_rp}, v.e_rp);
            check($sformatf("v%0d_rtn_allowIn", i), {31'b0, s_ra}, 1);
            check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, v.e_ov});
            check($sformatf("v%0d_out_ptr", i), {29'b0, out_ptr}, v.e_op);
            check($sformatf("v%0d_out_data", i), {24'b0, out_data}, {24'b0, v.e_od});
            check($sformatf("v%0d_issue_cnt", i), {16'b0, issue_cnt}, v.e_cnt);
        end

        // ---------------- backpressure ----------------
        set_in(1, 0, 8'hFF, 7, 0, 0, 1, 1, 8'h01, 1); cycle(1, s_rv, s_rp, s_ra);
        set_in(1, 1, 8'hFF, 7, 0, 0, 1, 1, 8'h5A, 1); cycle(1, s_rv, s_rp, s_ra);
        check("bp_first_out", {24'b0, out_data}, 32'h5A);
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 8'hFF, 7, 0, 0, 1, 1, 8'h6B + 8'(k), 0);
            cycle(1, s_rv, s_rp, s_ra);
            check("bp_rtn_allowIn", {31'b0, s_ra}, 0);
            check("bp_rd_valid", {31'b0, s_rv}, 0);
            check("bp_out_valid", {31'b0, out_valid}, 1);
            check("bp_data_stable", {24'b0, out_data}, 32'h5A);
        end
        set_in(0, 0, 8'hFF, 7, 0, 0, 1, 1, 8'h7D, 1); cycle(1, s_rv, s_rp, s_ra);
        check("bp_release_rd", {31'b0, s_rv}, 1);
        check("bp_release_ptr", {29'b0, s_rp}, 1);
        check("bp_release_out", {24'b0, out_data}, 32'h7D);
        check("bp_release_cnt", {16'b0, issue_cnt}, 10);

        // ---------------- flush ----------------
        for (int p = 2; p <= 4; p++) begin
            set_in(1, p, 8'hFF, 7, 0, 0, 1, 1, 8'h00, 0); cycle(1, s_rv, s_rp, s_ra);
        end
        set_in(1, 5, 8'hFF, 7, 0, 1, 1, 1, 8'hEE, 0); cycle(1, s_rv, s_rp, s_ra);
        check("fl_rd_valid", {31'b0, s_rv}, 0);
        check("fl_out_valid", {31'b0, out_valid}, 0);
        check("fl_issue_cnt", {16'b0, issue_cnt}, 10);
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 8'hFF, 7, 0, 0, 1, 1, 8'hEF, 1); cycle(1, s_rv, s_rp, s_ra);
            check("fl_after_rd_valid", {31'b0, s_rv}, 0);
        end

        // ---------------- async reset mid-stream ----------------
        set_in(1, 6, 8'hFF, 7, 0, 0, 1, 1, 8'h00, 1); cycle(1, s_rv, s_rp, s_ra);
        set_in(1, 7, 8'hFF, 7, 0, 0, 1, 1, 8'h9C, 0); cycle(1, s_rv, s_rp, s_ra);
        check("ar_pre_out_valid", {31'b0, out_valid}, 1);
        #2 rstn = 1'b0;
        #1;
        check("ar_out_valid", {31'b0, out_valid}, 0);
        check("ar_out_data", {24'b0, out_data}, 0);
        check("ar_out_ptr", {29'b0, out_ptr}, 0);
        check("ar_issue_cnt", {16'b0, issue_cnt}, 0);
        check("ar_rd_valid", {31'b0, rd_valid}, 0);
        check("ar_rtn_allowIn", {31'b0, rtn_allow}, 1);
        model_reset();
        set_in(0, 0, 8'hFF, 7, 0, 0, 1, 1, 8'h00, 1);
        @(posedge clk);
        #1 rstn = 1'b1;
        cycle(1, s_rv, s_rp, s_ra);
        check("ar_ready_cleared", {31'b0, s_rv}, 0);

        // ---------------- random vs model ----------------
        begin
            int bot_r;
            bit ord_r;
            bot_r = 7; ord_r = 0;
            for (int c = 0; c < 2000; c++) begin
                logic [7:0] bv_r;
                if (c % 64 == 0) ord_r = 1'($urandom_range(0, 1));
                if (c % 16 == 0) bot_r = $urandom_range(0, SIZE - 1);
                bv_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                set_in($urandom_range(0, 1) == 1, $urandom_range(0, SIZE - 1), bv_r, bot_r,
                       ord_r, $urandom_range(0, 31) == 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 4) != 0, 8'($urandom), $urandom_range(0, 9) < 7);
                cycle(1, s_rv, s_rp, s_ra);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
